// File: rtl/led_drv_pkg.sv
// Shared definitions for the LED PWM driver: the per-channel mode encoding.
package led_drv_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_PWM    = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: shadow/active configuration with period-aligned commit and
// the registered output compare. BLINK support only when LED_PWM_DRIVER_BLINK_EN.
module led_pwm_channel
  import led_drv_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  led_mode_e           wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                period_start,
  input  logic [PWM_BITS-1:0] pwm_cnt,
`ifdef LED_PWM_DRIVER_BLINK_EN
  input  logic                blink,
`endif
  input  logic                direct_bit,
  output logic                led,
  output logic                pending
);

  led_mode_e           act_mode_q, act_mode_d;
  logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
  led_mode_e           sh_mode_q, sh_mode_d;
  logic [PWM_BITS-1:0] sh_duty_q, sh_duty_d;
  logic                pend_q, pend_d;
  logic                led_q, led_d;

  always_comb begin
    act_mode_d = act_mode_q;
    act_duty_d = act_duty_q;
    sh_mode_d  = sh_mode_q;
    sh_duty_d  = sh_duty_q;
    pend_d     = pend_q;
    led_d      = 1'b0;
    if (period_start && pend_q) begin
      act_mode_d = sh_mode_q;
      act_duty_d = sh_duty_q;
      pend_d     = 1'b0;
    end
    if (wr_en) begin
      sh_mode_d = wr_mode;
      sh_duty_d = wr_duty;
      pend_d    = 1'b1;
    end
    // Compare against the post-commit config so a new setting starts exactly at count 0.
    case (act_mode_d)
      MODE_DIRECT: led_d = direct_bit;
      MODE_PWM:    led_d = (&act_duty_d) || (pwm_cnt < act_duty_d);
`ifdef LED_PWM_DRIVER_BLINK_EN
      MODE_BLINK:  led_d = blink;
`endif
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode_q <= MODE_DIRECT;
      act_duty_q <= '0;
      pend_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      act_mode_q <= act_mode_d;
      act_duty_q <= act_duty_d;
      pend_q     <= pend_d;
      led_q      <= led_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_mode_q <= sh_mode_d;
    sh_duty_q <= sh_duty_d;
  end

  assign led     = led_q;
  assign pending = pend_q;

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED driver: shared prescaler, PWM counter and blink divider
// feeding N_LED channels. Define LED_PWM_DRIVER_BLINK_EN to enable BLINK mode.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter  int N_LED      = 8,
  parameter  int PWM_BITS   = 8,
  parameter  int PRESCALE   = 16,
  parameter  int BLINK_BITS = 8,
  localparam int CH_W       = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_LED-1:0]    direct_in,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_chan,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  output logic [N_LED-1:0]    led,
  output logic                period_start
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                ps_q, ps_d;
  logic                step, wrap;
  logic                chan_ok, accept;
  logic [N_LED-1:0]    pending;
`ifdef LED_PWM_DRIVER_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q, blink_d;
`endif

  always_comb begin
    step  = (pre_q == PRE_W'(PRESCALE - 1));
    pre_d = step ? '0 : pre_q + PRE_W'(1);
    cnt_d = step ? cnt_q + PWM_BITS'(1) : cnt_q;
    wrap  = step && (&cnt_q);
    ps_d  = wrap;
`ifdef LED_PWM_DRIVER_BLINK_EN
    blink_d = wrap ? blink_q + BLINK_BITS'(1) : blink_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
`ifdef LED_PWM_DRIVER_BLINK_EN
      blink_q <= '0;
`endif
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
`ifdef LED_PWM_DRIVER_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  // Out-of-range channels are never pending, so such writes are accepted and dropped.
  assign chan_ok  = ({{(32-CH_W){1'b0}}, wr_chan} < 32'(N_LED));
  assign wr_ready = !rst && !(chan_ok && pending[wr_chan]);
  assign accept   = wr_valid && wr_ready && chan_ok;

  for (genvar g = 0; g < N_LED; g++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (accept && (wr_chan == CH_W'(g))),
      .wr_mode      (led_mode_e'(wr_mode)),
      .wr_duty      (wr_duty),
      .period_start (ps_q),
      .pwm_cnt      (cnt_q),
`ifdef LED_PWM_DRIVER_BLINK_EN
      .blink        (blink_q[BLINK_BITS-1]),
`endif
      .direct_bit   (direct_in[g]),
      .led          (led[g]),
      .pending      (pending[g])
    );
  end

  assign period_start = ps_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: time-indexed reference model plus directed scenarios.
module tb_led_pwm_driver;
  import led_drv_pkg::*;

  localparam int N   = 8;
  localparam int PB  = 4;
  localparam int PS  = 2;
  localparam int BB  = 2;
  localparam int PER = PS * (1 << PB);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] direct_in = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_chan = 3'd0;
  logic [1:0] wr_mode = 2'b00;
  logic [3:0] wr_duty = 4'd0;
  logic [7:0] led;
  logic       period_start;

  logic [5:0] direct6 = 6'h2A;
  logic       wr_valid6 = 1'b1;
  logic [2:0] wr_chan6 = 3'd7;
  logic [1:0] wr_mode6 = 2'b11;
  logic [3:0] wr_duty6 = 4'd0;
  logic       wr_ready6;
  logic [5:0] led6;
  logic       ps6;

  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;

  always #5 clk = ~clk;

  led_pwm_driver #(.N_LED(N), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_BITS(BB)) u_dut (
    .clk(clk), .rst(rst), .direct_in(direct_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_chan(wr_chan), .wr_mode(wr_mode), .wr_duty(wr_duty), .led(led),
    .period_start(period_start)
  );

  led_pwm_driver #(.N_LED(6), .PWM_BITS(PB), .PRESCALE(PS), .BLINK_BITS(BB)) u_dut6 (
    .clk(clk), .rst(rst), .direct_in(direct6), .wr_valid(wr_valid6), .wr_ready(wr_ready6),
    .wr_chan(wr_chan6), .wr_mode(wr_mode6), .wr_duty(wr_duty6), .led(led6),
    .period_start(ps6)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: everything is a function of k = clock edges since reset release.
  function automatic logic led_of(input logic [1:0] m, input logic [3:0] d, input int k,
                                  input logic dir);
    int cnt;
    int bl;
    cnt = (k / PS) % (1 << PB);
    bl  = (k / PER) % (1 << BB);
    case (m)
      2'b00:   return dir;
      2'b01:   return (d == 4'hF) || (cnt < int'(d));
`ifdef LED_PWM_DRIVER_BLINK_EN
      2'b10:   return bl >= (1 << (BB - 1));
`endif
      default: return 1'b0;
    endcase
  endfunction

  int         k_m;
  logic [1:0] act_m [N];
  logic [3:0] actd_m[N];
  logic [1:0] sh_m  [N];
  logic [3:0] shd_m [N];
  logic       pend_m[N];
  logic [7:0] led_m;

  always @(posedge clk) begin : model
    if (rst) begin
      k_m   <= 0;
      led_m <= '0;
      for (int i = 0; i < N; i++) begin
        act_m[i]  <= 2'b00;
        actd_m[i] <= '0;
        pend_m[i] <= 1'b0;
      end
    end else begin
      k_m <= k_m + 1;
      for (int i = 0; i < N; i++) begin
        if (k_m > 0 && (k_m % PER) == 0 && pend_m[i]) begin
          act_m[i]  <= sh_m[i];
          actd_m[i] <= shd_m[i];
          pend_m[i] <= 1'b0;
          led_m[i]  <= led_of(sh_m[i], shd_m[i], k_m, direct_in[i]);
        end else begin
          led_m[i]  <= led_of(act_m[i], actd_m[i], k_m, direct_in[i]);
        end
        if (wr_valid && !pend_m[i] && int'(wr_chan) == i) begin
          sh_m[i]   <= wr_mode;
          shd_m[i]  <= wr_duty;
          pend_m[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk("led", int'(led), int'(led_m));
      chk("period_start", int'(period_start), int'(k_m > 0 && (k_m % PER) == 0));
      chk("wr_ready", int'(wr_ready), int'(!rst && !pend_m[wr_chan]));
      chk("led6_oob", int'(led6), (k_m > 0) ? 'h2A : 0);
      chk("wr_ready6_oob", int'(wr_ready6), int'(!rst));
      chk("ps6", int'(ps6), int'(k_m > 0 && (k_m % PER) == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    while (!period_start && n < 200) begin
      tick();
      n++;
    end
    if (!period_start) chk("wait_ps_timeout", 0, 1);
  endtask

  task automatic write_cfg(input int ch, input logic [1:0] m, input logic [3:0] d);
    int n;
    wr_valid = 1'b1;
    wr_chan  = 3'(ch);
    wr_mode  = m;
    wr_duty  = d;
    #1;
    n = 0;
    while (!wr_ready && n < 200) begin
      tick();
      #1;
      n++;
    end
    if (!wr_ready) chk("write_timeout", 0, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic measure(input int ch, input int n, output int highs);
    wait_ps();
    tick();
    highs = 0;
    repeat (n) begin
      highs += int'(led[ch]);
      tick();
    end
  endtask

  initial begin : stim
    int n;
    int h;
    direct_in = 8'hA5;
    tick();
    started = 1'b1;
    tick();
    tick();
    chk("rst_led", int'(led), 0);
    chk("rst_ready", int'(wr_ready), 0);
    rst = 1'b0;
    tick();
    chk("direct_A5", int'(led), 'hA5);

    n = 1;
    while (!period_start && n < 200) begin
      tick();
      n++;
    end
    chk("first_ps_cycles", n, 32);

    write_cfg(3, MODE_PWM, 4'd4);
    measure(3, PER, h);
    chk("pwm_duty4_highs", h, 8);
    write_cfg(3, MODE_PWM, 4'd0);
    measure(3, PER, h);
    chk("pwm_duty0_highs", h, 0);
    write_cfg(3, MODE_PWM, 4'd15);
    measure(3, PER, h);
    chk("pwm_duty15_highs", h, 32);

    write_cfg(1, MODE_PWM, 4'd8);
    wr_valid = 1'b1;
    wr_chan  = 3'd1;
    wr_mode  = MODE_PWM;
    wr_duty  = 4'd2;
    #1;
    chk("b2b_stall", int'(wr_ready), 0);
    wait_ps();
    chk("b2b_ps_ready", int'(wr_ready), 0);
    tick();
    chk("b2b_after_ps_ready", int'(wr_ready), 1);
    tick();
    wr_valid = 1'b0;
    measure(1, PER, h);
    chk("b2b_duty2_highs", h, 4);

    write_cfg(2, MODE_BLINK, 4'd9);
    measure(2, 4 * PER, h);
`ifdef LED_PWM_DRIVER_BLINK_EN
    chk("blink_highs", h, 2 * PER);
`else
    chk("blink_highs", h, 0);
`endif

    wait_ps();
    tick();
    write_cfg(0, MODE_PWM, 4'd10);
    write_cfg(5, MODE_OFF, 4'd0);
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mid_led", int'(led), 0);
    rst = 1'b0;
    direct_in = 8'hFF;
    tick();
    chk("rst_discard_direct", int'(led), 'hFF);
    wait_ps();
    tick();
    tick();
    chk("rst_discard_after_ps", int'(led), 'hFF);

    for (int i = 0; i < 3000; i++) begin
      direct_in = 8'($urandom);
      wr_valid  = ($urandom % 3) == 0;
      wr_chan   = 3'($urandom);
      wr_mode   = 2'($urandom);
      wr_duty   = 4'($urandom);
      rst       = ($urandom % 500) == 0;
      tick();
    end
    rst = 1'b0;
    wr_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
